// File: rtl/acc_sched_pkg.sv
// Shared types and default widths for the accumulator scheduler.
package acc_sched_pkg;

  localparam int unsigned N_DEF  = 4;
  localparam int unsigned W_DEF  = 8;
  localparam int unsigned SW_DEF = 16;
  localparam int unsigned CW_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    BURST,
    DRAIN,
    RESULT,
    CLEAR
  } acc_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_id
);

  logic [IW-1:0] idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IW'((32'(ptr) + k) % N);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
  end

endmodule

// File: rtl/acc_sched.sv
// Round-robin scheduler sharing one external accumulator between N burst
// requesters; returns each burst's final sum tagged with requester id and count.
module acc_sched
  import acc_sched_pkg::*;
#(
  parameter  int unsigned N  = N_DEF,
  parameter  int unsigned W  = W_DEF,
  parameter  int unsigned SW = SW_DEF,
  parameter  int unsigned CW = CW_DEF,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [N*W-1:0]  req_data,
  input  logic [N-1:0]    req_last,
  output logic [N-1:0]    req_ready,
  output logic [W-1:0]    acc_in,
  output logic            acc_clr,
  input  logic [SW-1:0]   acc_sum,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [IW-1:0]   res_id,
  output logic [SW-1:0]   res_sum,
  output logic [CW-1:0]   res_count
);

  acc_state_e    state;
  logic [IW-1:0] gnt_id;
  logic [IW-1:0] rr_ptr;
  logic [CW-1:0] count;
  logic          arb_valid;
  logic [IW-1:0] arb_id;
  logic          accept;
  logic [W-1:0]  gnt_data;

  rr_arbiter #(.N(N)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .gnt_valid (arb_valid),
    .gnt_id    (arb_id)
  );

  // Ready and the accumulator input are decoded from registered state so a
  // non-accept cycle feeds zero and the accumulator simply holds.
  always_comb begin
    req_ready = '0;
    if (state == BURST) req_ready[gnt_id] = 1'b1;
    gnt_data = req_data[32'(gnt_id)*W +: W];
    accept   = (state == BURST) && req_valid[gnt_id];
    acc_in   = accept ? gnt_data : '0;
  end

  assign acc_clr   = rst | (state == CLEAR);
  assign res_count = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt_id    <= '0;
      rr_ptr    <= '0;
      count     <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_sum   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            gnt_id <= arb_id;
            rr_ptr <= (arb_id == IW'(N - 1)) ? '0 : arb_id + 1'b1;
            count  <= '0;
            state  <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            if (count != '1) count <= count + 1'b1;
            if (req_last[gnt_id]) state <= DRAIN;
          end
        end
        DRAIN: begin
          res_sum   <= acc_sum;
          res_id    <= gnt_id;
          res_valid <= 1'b1;
          state     <= RESULT;
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= CLEAR;
          end
        end
        CLEAR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_sched.sv
// Randomised and directed bench for acc_sched against a timestamp-based
// transaction model, with a behavioural accumulator attached to the DUT.
module tb_acc_sched;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 16;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last  = '0;
  logic [N*W-1:0]  req_data  = '0;
  logic [N-1:0]    req_ready;
  logic [W-1:0]    acc_in;
  logic            acc_clr;
  logic [SW-1:0]   acc_sum = '0;
  logic            res_valid;
  logic            res_ready = 1'b1;
  logic [1:0]      res_id;
  logic [SW-1:0]   res_sum;
  logic [CW-1:0]   res_count;

  always #5 clk = ~clk;

  acc_sched #(.N(N), .W(W), .SW(SW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .acc_in    (acc_in),
    .acc_clr   (acc_clr),
    .acc_sum   (acc_sum),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_sum   (res_sum),
    .res_count (res_count)
  );

  // Accumulator: sum updates on the edge after the accept cycle.
  always @(posedge clk) acc_sum <= acc_clr ? '0 : acc_sum + SW'(acc_in);

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct { logic [W-1:0] d; bit last; int gap; } word_t;
  typedef struct { int id; int sum; int cnt; } res_t;
  word_t q[N][$];
  res_t  log_q[$];

  // Model: one burst in flight, described by the cycle numbers of its events.
  int       m_owner = -1, m_gcyc = 0, m_lcyc = 0, m_hcyc = 0, m_free = 0, m_ptr = 0;
  bit       m_lastseen = 0, m_hsdone = 0;
  int       m_sum = 0, m_cnt = 0;
  logic [N-1:0] acc_mask = '0;
  int       n_acc = 0;
  int       rdy_mode = 0;
  int       bp_cnt = 0;

  always @(negedge clk) begin : compare
    logic [N-1:0] e_ready;
    logic [W-1:0] wd, e_in;
    bit           e_rv, e_clr, acc_hit;
    cyc++;
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_acc_in", acc_in, 0);
      chk("rst_acc_clr", acc_clr, 1);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_id", res_id, 0);
      chk("rst_res_sum", res_sum, 0);
      chk("rst_res_count", res_count, 0);
      m_owner = -1; m_ptr = 0; m_free = 0; acc_mask = '0;
    end else begin
      e_ready = '0;
      wd = '0;
      if (m_owner >= 0) begin
        if (!m_lastseen && cyc > m_gcyc) e_ready[m_owner] = 1'b1;
        wd = req_data[m_owner*W +: W];
      end
      e_rv    = (m_owner >= 0) && m_lastseen && !m_hsdone && (cyc >= m_lcyc + 2);
      e_clr   = (m_owner >= 0) && m_hsdone && (cyc == m_hcyc + 1);
      acc_hit = (req_valid & e_ready) != '0;
      e_in    = acc_hit ? wd : '0;
      chk("req_ready", req_ready, e_ready);
      chk("acc_in", acc_in, e_in);
      chk("acc_clr", acc_clr, e_clr);
      chk("res_valid", res_valid, e_rv);
      if (e_rv) begin
        chk("res_id", res_id, m_owner);
        chk("res_sum", res_sum, m_sum);
        chk("res_count", res_count, m_cnt);
      end
      acc_mask = req_valid & req_ready;
      if (acc_hit) begin
        n_acc++;
        m_sum = (m_sum + int'(wd)) % (1 << SW);
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        if (req_last[m_owner]) begin m_lastseen = 1; m_lcyc = cyc; end
      end
      if (e_rv && res_ready) begin
        m_hsdone = 1; m_hcyc = cyc;
        log_q.push_back('{int'(res_id), int'(res_sum), int'(res_count)});
      end
      if (e_clr) begin
        m_owner = -1; m_free = cyc + 1;
      end else if (m_owner < 0 && cyc >= m_free && req_valid != '0) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && req_valid[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        end
        m_gcyc = cyc; m_ptr = (m_owner + 1) % N;
        m_sum = 0; m_cnt = 0; m_lastseen = 0; m_hsdone = 0;
      end
    end
  end

  task automatic push(input int i, input int d, input bit last, input int gap);
    q[i].push_back('{W'(d), last, gap});
  endtask

  task automatic drive_cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && acc_mask[i]) begin
        void'(q[i].pop_front());
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
      if (!req_valid[i] && q[i].size() > 0) begin
        if (q[i][0].gap > 0) q[i][0].gap = q[i][0].gap - 1;
        else begin
          req_valid[i]         = 1'b1;
          req_data[i*W +: W]   = q[i][0].d;
          req_last[i]          = q[i][0].last;
        end
      end
      if (!req_valid[i]) req_data[i*W +: W] = W'($urandom);
    end
    case (rdy_mode)
      0: res_ready = 1'b1;
      1: res_ready = ($urandom_range(0, 9) < 7);
      default: begin
        if (res_valid) bp_cnt++; else bp_cnt = 0;
        res_ready = (bp_cnt > 5);
      end
    endcase
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) if (q[i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic wait_idle(input int budget);
    int idle = 0;
    for (int c = 0; c < budget; c++) begin
      drive_cycle();
      if (queues_empty() && req_valid == '0 && m_owner < 0) idle++; else idle = 0;
      if (idle >= 3) return;
    end
    n_cmp++; n_fail++;
    $display("FAIL wait_idle: timed out after %0d cycles, required idle", budget);
  endtask

  task automatic chk_res(input int idx, input int id, input int sum, input int cnt);
    if (idx >= log_q.size()) begin
      n_cmp++; n_fail++;
      $display("FAIL result_%0d: missing, got %0d results required > %0d", idx, log_q.size(), idx);
    end else begin
      chk("lit_res_id", log_q[idx].id, id);
      chk("lit_res_sum", log_q[idx].sum, sum);
      chk("lit_res_count", log_q[idx].cnt, cnt);
    end
  endtask

  initial begin
    int base;
    int n0;
    bit hit;
    rst = 1'b1;
    repeat (3) drive_cycle();
    rst = 1'b0;

    // All four at once, then requester 0 again: order 0,1,2,3,0.
    base = log_q.size();
    for (int i = 0; i < N; i++) push(i, 10 + i, 1, 0);
    push(0, 20, 1, 0);
    wait_idle(200);
    for (int i = 0; i < N; i++) chk_res(base + i, i, 10 + i, 1);
    chk_res(base + 4, 0, 20, 1);

    base = log_q.size();
    push(1, 3, 0, 0); push(1, 5, 0, 0); push(1, 7, 1, 0);
    wait_idle(200);
    chk_res(base, 1, 15, 3);

    base = log_q.size();
    push(2, 4, 0, 0); push(2, 6, 1, 3);
    wait_idle(200);
    chk_res(base, 2, 10, 2);

    rdy_mode = 2;
    base = log_q.size();
    push(3, 33, 1, 0); push(1, 2, 1, 0);
    wait_idle(200);
    chk_res(base, 3, 33, 1);
    chk_res(base + 1, 1, 2, 1);
    rdy_mode = 0;

    base = log_q.size();
    for (int k = 0; k < 300; k++) push(0, 255, k == 299, 0);
    wait_idle(1000);
    chk_res(base, 0, 10964, 255);

    rdy_mode = 1;
    base = log_q.size();
    for (int b = 0; b < 40; b++) begin
      int r, len;
      r   = $urandom_range(0, N - 1);
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) push(r, $urandom_range(0, 255), k == len - 1, $urandom_range(0, 2));
    end
    wait_idle(5000);
    chk("random_result_count", log_q.size() - base, 40);
    rdy_mode = 0;

    // Asynchronous reset after two accepted words of a five-word burst.
    n0 = n_acc;
    for (int k = 1; k <= 5; k++) push(0, k, k == 5, 0);
    hit = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      drive_cycle();
      if (n_acc >= n0 + 2) hit = 1;
    end
    if (!hit) begin
      n_cmp++; n_fail++;
      $display("FAIL reset_wait: accepted %0d words, required 2", n_acc - n0);
    end
    #2 rst = 1'b1;
    #1;
    chk("async_req_ready", req_ready, 0);
    chk("async_res_valid", res_valid, 0);
    chk("async_acc_clr", acc_clr, 1);
    for (int i = 0; i < N; i++) q[i].delete();
    req_valid = '0;
    req_last  = '0;
    repeat (2) drive_cycle();
    rst = 1'b0;
    base = log_q.size();
    push(3, 9, 1, 0);
    wait_idle(200);
    chk_res(base, 3, 9, 1);
    chk("post_reset_result_count", log_q.size() - base, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
